// File: rtl/cp0_except_ctrl.sv
`timescale 1ns/1ps
// cp0_except_ctrl: sequences the CP0 register writes for exception entry and
// eret. The block stalls the pipeline while it writes EPC, Cause and Status
// through the CP0 write port, then flushes the pipeline for one cycle and
// redirects fetch. WB-stage mtc0 writes are forwarded so that decisions use
// the values the CP0 registers are about to hold.
module cp0_except_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] pc_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_data_o,
   output logic        stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
   localparam logic [4:0]  ADDR_STATUS = 5'd12;
   localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
   localparam logic [4:0]  ADDR_EPC    = 5'd14;
   localparam logic [4:0]  EXC_INT = 5'h00;
   localparam logic [4:0]  EXC_SYS = 5'h08;
   localparam logic [4:0]  EXC_RI  = 5'h0a;
   localparam logic [4:0]  EXC_TR  = 5'h0d;
   localparam logic [4:0]  EXC_OV  = 5'h0c;

   typedef enum logic [2:0] {
      S_IDLE,
      S_W_EPC,
      S_W_CAUSE,
      S_W_STATUS,
      S_W_ERET,
      S_REDIRECT
   } state_t;

   state_t      state, state_nx;
   logic [31:0] eff_status, eff_cause, eff_epc;
   logic        irq_pending;
   logic        exc_hit, eret_hit;
   logic [4:0]  exc_code;

   logic [4:0]  cap_code;
   logic [31:0] cap_pc;
   logic        cap_bd;
   logic [31:0] cap_status;
   logic [31:0] cap_cause;
   logic [31:0] cap_target;

   // Forward a pending WB-stage mtc0 write into the effective CP0 view.
   always_comb begin
      eff_status = status_i;
      eff_cause  = cause_i;
      eff_epc    = epc_i;
      if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_STATUS)) eff_status = wb_cp0_data_i;
      if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_EPC))    eff_epc    = wb_cp0_data_i;
      if (wb_cp0_we_i && (wb_cp0_waddr_i == ADDR_CAUSE))  eff_cause[9:8] = wb_cp0_data_i[9:8];
      irq_pending = eff_status[0] && !eff_status[1] &&
                    ((eff_cause[15:8] & eff_status[15:8]) != 8'h00);
   end

   // Prioritise pending events; a zero pc marks a bubble, so only interrupts count there.
   always_comb begin
      exc_hit  = 1'b0;
      eret_hit = 1'b0;
      exc_code = EXC_INT;
      if (irq_pending) begin
         exc_hit = 1'b1;
      end else if (pc_i != 32'h0) begin
         if (excepttype_i[8]) begin
            exc_hit = 1'b1; exc_code = EXC_SYS;
         end else if (excepttype_i[9]) begin
            exc_hit = 1'b1; exc_code = EXC_RI;
         end else if (excepttype_i[10]) begin
            exc_hit = 1'b1; exc_code = EXC_TR;
         end else if (excepttype_i[11]) begin
            exc_hit = 1'b1; exc_code = EXC_OV;
         end else if (excepttype_i[12]) begin
            eret_hit = 1'b1;
         end
      end
   end

   // State register and event capture; captures only change on an IDLE detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cap_code   <= 5'h0;
         cap_pc     <= 32'h0;
         cap_bd     <= 1'b0;
         cap_status <= 32'h0;
         cap_cause  <= 32'h0;
         cap_target <= 32'h0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE) begin
            if (exc_hit) begin
               cap_code   <= exc_code;
               cap_pc     <= pc_i;
               cap_bd     <= is_in_delayslot_i;
               cap_status <= eff_status;
               cap_cause  <= eff_cause;
               cap_target <= EXC_VECTOR;
            end else if (eret_hit) begin
               cap_status <= eff_status;
               cap_target <= eff_epc;
            end
         end
      end
   end

   // Next state and outputs; everything is forced low while reset is held.
   always_comb begin
      state_nx    = state;
      cp0_we_o    = 1'b0;
      cp0_waddr_o = 5'h0;
      cp0_data_o  = 32'h0;
      stall_o     = 1'b0;
      flush_o     = 1'b0;
      new_pc_o    = 32'h0;
      case (state)
         S_IDLE: begin
            if (exc_hit) begin
               stall_o  = 1'b1;
               state_nx = S_W_EPC;
            end else if (eret_hit) begin
               stall_o  = 1'b1;
               state_nx = S_W_ERET;
            end
         end
         S_W_EPC: begin
            stall_o     = 1'b1;
            cp0_we_o    = 1'b1;
            cp0_waddr_o = ADDR_EPC;
            cp0_data_o  = cap_bd ? (cap_pc - 32'd4) : cap_pc;
            state_nx    = S_W_CAUSE;
         end
         S_W_CAUSE: begin
            stall_o     = 1'b1;
            cp0_we_o    = 1'b1;
            cp0_waddr_o = ADDR_CAUSE;
            cp0_data_o  = {cap_bd, cap_cause[30:7], cap_code, cap_cause[1:0]};
            state_nx    = S_W_STATUS;
         end
         S_W_STATUS: begin
            stall_o     = 1'b1;
            cp0_we_o    = 1'b1;
            cp0_waddr_o = ADDR_STATUS;
            cp0_data_o  = cap_status | 32'h0000_0002;
            state_nx    = S_REDIRECT;
         end
         S_W_ERET: begin
            stall_o     = 1'b1;
            cp0_we_o    = 1'b1;
            cp0_waddr_o = ADDR_STATUS;
            cp0_data_o  = cap_status & ~32'h0000_0002;
            state_nx    = S_REDIRECT;
         end
         S_REDIRECT: begin
            flush_o  = 1'b1;
            new_pc_o = cap_target;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (!rst) begin
         cp0_we_o    = 1'b0;
         cp0_waddr_o = 5'h0;
         cp0_data_o  = 32'h0;
         stall_o     = 1'b0;
         flush_o     = 1'b0;
         new_pc_o    = 32'h0;
      end
   end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
`timescale 1ns/1ps
// Bench for cp0_except_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a schedule-based model.
module tb_cp0_except_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] excepttype_i = '0;
   logic [31:0] pc_i = '0;
   logic        is_in_delayslot_i = 1'b0;
   logic [31:0] status_i = '0, cause_i = '0, epc_i = '0;
   logic        wb_cp0_we_i = 1'b0;
   logic [4:0]  wb_cp0_waddr_i = '0;
   logic [31:0] wb_cp0_data_i = '0;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_data_o;
   logic        stall_o, flush_o;
   logic [31:0] new_pc_o;

   // next-cycle input set, applied by tick()
   logic        nx_rst = 1'b0;
   logic [31:0] nx_et = '0, nx_pc = '0, nx_st = '0, nx_ca = '0, nx_ep = '0, nx_wd = '0;
   logic        nx_bd = 1'b0, nx_wbwe = 1'b0;
   logic [4:0]  nx_wa = '0;

   int total = 0;
   int bad   = 0;

   logic [71:0] exp_q[$];
   logic [71:0] exp_now = '0;
   logic [71:0] dut_vec;

   cp0_except_ctrl dut (
      .clk(clk), .rst(rst),
      .excepttype_i(excepttype_i), .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
      .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_data_o(cp0_data_o),
      .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
   );

   assign dut_vec = {cp0_we_o, cp0_waddr_o, cp0_data_o, stall_o, flush_o, new_pc_o};

   // clock
   always #5 clk = ~clk;

   function automatic logic [71:0] pk(input logic we, input logic [4:0] a, input logic [31:0] d,
                                      input logic st, input logic fl, input logic [31:0] np);
      return {we, a, d, st, fl, np};
   endfunction

   // Model: an accepted event schedules the exact outputs of the following cycles.
   task automatic model_step();
      logic [31:0] est, eepc, ec, epc_val;
      logic        irq, take, eret;
      logic [4:0]  code;
      if (!rst) begin
         exp_q.delete();
         exp_now = '0;
         return;
      end
      if (exp_q.size() > 0) begin
         exp_now = exp_q.pop_front();
         return;
      end
      est  = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : status_i;
      eepc = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : epc_i;
      ec   = cause_i;
      if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) ec[9:8] = wb_cp0_data_i[9:8];
      irq  = est[0] && !est[1] && ((ec[15:8] & est[15:8]) != 0);
      take = 1'b0; eret = 1'b0; code = 5'h0;
      if (irq) take = 1'b1;
      else if (pc_i != 0) begin
         if (excepttype_i[8])       begin take = 1'b1; code = 5'h08; end
         else if (excepttype_i[9])  begin take = 1'b1; code = 5'h0a; end
         else if (excepttype_i[10]) begin take = 1'b1; code = 5'h0d; end
         else if (excepttype_i[11]) begin take = 1'b1; code = 5'h0c; end
         else if (excepttype_i[12]) eret = 1'b1;
      end
      exp_now = pk(1'b0, 5'd0, 32'h0, take | eret, 1'b0, 32'h0);
      if (take) begin
         epc_val = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
         exp_q.push_back(pk(1'b1, 5'd14, epc_val, 1'b1, 1'b0, 32'h0));
         exp_q.push_back(pk(1'b1, 5'd13, {is_in_delayslot_i, ec[30:7], code, ec[1:0]}, 1'b1, 1'b0, 32'h0));
         exp_q.push_back(pk(1'b1, 5'd12, est | 32'h2, 1'b1, 1'b0, 32'h0));
         exp_q.push_back(pk(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h20));
      end else if (eret) begin
         exp_q.push_back(pk(1'b1, 5'd12, est & ~32'h2, 1'b1, 1'b0, 32'h0));
         exp_q.push_back(pk(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, eepc));
      end
   endtask

   // Compare process: every cycle, away from the rising edge.
   always @(negedge clk) begin
      total++;
      if (dut_vec !== exp_now) begin
         bad++;
         $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, dut_vec, exp_now);
      end
   end

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   // Driver: apply next inputs just after the edge, advance model, return after compare.
   task automatic tick();
      @(posedge clk);
      #1;
      rst = nx_rst; excepttype_i = nx_et; pc_i = nx_pc; is_in_delayslot_i = nx_bd;
      status_i = nx_st; cause_i = nx_ca; epc_i = nx_ep;
      wb_cp0_we_i = nx_wbwe; wb_cp0_waddr_i = nx_wa; wb_cp0_data_i = nx_wd;
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_idle();
      nx_et = 0; nx_pc = 32'h8000_0100; nx_bd = 0; nx_st = 0; nx_ca = 0; nx_ep = 0;
      nx_wbwe = 0; nx_wa = 0; nx_wd = 0;
   endtask

   initial begin
      // reset
      set_idle(); nx_rst = 1'b0;
      nx_et = 32'h100; nx_st = 32'h0000_0401; nx_ca = 32'h400;
      tick(); tick();
      lit("rst_stall", {31'b0, stall_o}, 32'h0);
      lit("rst_we", {31'b0, cp0_we_o}, 32'h0);
      lit("rst_flush", {31'b0, flush_o}, 32'h0);
      nx_rst = 1'b1; set_idle();
      tick(); tick();

      // syscall
      nx_et = 32'h100; nx_pc = 32'h8000_1000; nx_st = 32'h0040_0000;
      tick(); lit("sys_stall", {31'b0, stall_o}, 32'h1);
      set_idle();
      tick(); lit("sys_epc_addr", {27'b0, cp0_waddr_o}, 32'd14);
      lit("sys_epc", cp0_data_o, 32'h8000_1000);
      tick(); lit("sys_code", {27'b0, cp0_data_o[6:2]}, 32'h08);
      tick(); lit("sys_status", cp0_data_o, 32'h0040_0002);
      tick(); lit("sys_flush", {31'b0, flush_o}, 32'h1);
      lit("sys_newpc", new_pc_o, 32'h20);
      tick(); lit("sys_done", {31'b0, stall_o}, 32'h0);

      // delay-slot overflow
      nx_et = 32'h800; nx_pc = 32'h8000_2004; nx_bd = 1;
      tick(); set_idle();
      tick(); lit("ov_epc", cp0_data_o, 32'h8000_2000);
      tick(); lit("ov_cause", cp0_data_o, 32'h8000_0030);
      tick(); tick(); tick();

      // interrupt, then masked by EXL
      nx_st = 32'h0000_0401; nx_ca = 32'h400; nx_pc = 32'h0;
      tick(); set_idle();
      tick(); tick(); lit("int_cause", cp0_data_o, 32'h0000_0400);
      tick(); lit("int_status", cp0_data_o, 32'h0000_0403);
      tick(); lit("int_newpc", new_pc_o, 32'h20);
      nx_st = 32'h0000_0403; nx_ca = 32'h400;
      tick(); lit("int_masked", {31'b0, stall_o}, 32'h0);
      tick(); lit("int_masked_we", {31'b0, cp0_we_o}, 32'h0);
      set_idle();

      // eret with forwarded EPC
      nx_et = 32'h1000; nx_pc = 32'h8000_4000; nx_st = 32'h0000_ff03; nx_ep = 32'h100;
      nx_wbwe = 1; nx_wa = 5'd14; nx_wd = 32'h8000_3000;
      tick(); set_idle();
      tick(); lit("eret_status", cp0_data_o, 32'h0000_ff01);
      tick(); lit("eret_newpc", new_pc_o, 32'h8000_3000);

      // syscall+overflow, flags during writes ignored, event right after redirect
      nx_et = 32'h900; nx_pc = 32'h8000_5000;
      tick(); tick();
      nx_et = 32'h200;
      tick(); lit("pri_code", {27'b0, cp0_data_o[6:2]}, 32'h08);
      tick(); tick();
      nx_pc = 32'h10;
      tick(); lit("back2back", {31'b0, stall_o}, 32'h1);
      set_idle();
      tick(); tick(); tick(); tick(); tick();

      // bubble pc=0 ignores flags
      nx_et = 32'h100; nx_pc = 32'h0;
      tick(); lit("pc0_ignored", {31'b0, stall_o}, 32'h0);
      set_idle();

      // reset during W_CAUSE
      nx_et = 32'h100;
      tick(); set_idle();
      tick(); tick();
      lit("mid_in_cause", {27'b0, cp0_waddr_o}, 32'd13);
      rst = 1'b0; nx_rst = 1'b0;
      #1;
      lit("mid_rst_we", {31'b0, cp0_we_o}, 32'h0);
      lit("mid_rst_stall", {31'b0, stall_o}, 32'h0);
      tick(); tick();
      nx_rst = 1'b1;
      tick(); tick(); tick(); tick();
      lit("mid_no_flush", {31'b0, flush_o}, 32'h0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: nx_et = 32'h0;
            default:          nx_et = ($urandom & 32'h1f) << 8;
         endcase
         case ($urandom_range(0, 7))
            0:       nx_pc = 32'h0;
            1:       nx_pc = $urandom_range(0, 3);
            default: nx_pc = $urandom;
         endcase
         nx_bd = $urandom_range(0, 1);
         nx_st = $urandom; nx_ca = $urandom; nx_ep = $urandom;
         nx_wbwe = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: nx_wa = 5'd12;
            1: nx_wa = 5'd13;
            2: nx_wa = 5'd14;
            default: nx_wa = 5'($urandom_range(0, 31));
         endcase
         nx_wd = $urandom;
         nx_rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      nx_rst = 1'b1; set_idle();
      for (int i = 0; i < 6; i++) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
